// File: rtl/pll_seq_pkg.sv
// PLL lock sequencer shared types.
// State encoding and loss-counter width.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    S_PLLRST,
    S_WAIT,
    S_RELEASE,
    S_RUN,
    S_FAULT
  } pll_seq_state_t;

  localparam int LOSS_CNT_W = 16;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser.
// Async clear to RST_VAL, two-cycle latency.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL supervisor: qualifies lock, retries on timeout,
// then releases downstream resets one channel at a time.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 64,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int NUM_CH              = 4,
  parameter int STAGGER_CYCLES      = 16,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                  clkin,
  input  logic                  reset_n,
  input  logic                  lock_in,
  input  logic                  restart,
  output logic                  pll_reset,
  output logic [NUM_CH-1:0]     ch_rst_n,
  output logic                  ready,
  output logic                  fault,
  output logic [7:0]            retry_cnt,
  output logic [LOSS_CNT_W-1:0] loss_cnt
);

  localparam int RST_W    = $clog2(PLL_RST_CYCLES + 1);
  localparam int STB_W    = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TO_W     = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int REL_LAST = (NUM_CH - 1) * STAGGER_CYCLES + 1;
  localparam int REL_W    = $clog2(REL_LAST + 1);

  logic rst_sync_n;
  logic lock_s;

  pll_seq_state_t state, state_n;

  logic [RST_W-1:0] rst_cnt, rst_cnt_n;
  logic [STB_W-1:0] stb_cnt, stb_cnt_n;
  logic [TO_W-1:0]  to_cnt, to_cnt_n;
  logic [REL_W-1:0] rel_cnt, rel_cnt_n;

  logic                  pll_reset_n;
  logic [NUM_CH-1:0]     ch_n;
  logic                  ready_n;
  logic                  fault_n;
  logic [7:0]            retry_n;
  logic [LOSS_CNT_W-1:0] loss_n;

  sync_2ff #(.RST_VAL(1'b0)) u_rst_sync (
    .clk   (clkin),
    .rst_n (reset_n),
    .d     (1'b1),
    .q     (rst_sync_n)
  );

  sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
    .clk   (clkin),
    .rst_n (reset_n),
    .d     (lock_in),
    .q     (lock_s)
  );

  // Next state, counters and registered-output values
  always_comb begin
    state_n   = state;
    rst_cnt_n = rst_cnt;
    stb_cnt_n = stb_cnt;
    to_cnt_n  = to_cnt;
    rel_cnt_n = rel_cnt;
    retry_n   = retry_cnt;
    loss_n    = loss_cnt;
    ch_n      = '0;

    if (restart) begin
      state_n   = S_PLLRST;
      rst_cnt_n = '0;
      retry_n   = '0;
    end else begin
      unique case (state)
        S_PLLRST: begin
          if (rst_cnt == RST_W'(PLL_RST_CYCLES - 1))
            state_n = S_WAIT;
          else
            rst_cnt_n = rst_cnt + 1'b1;
        end
        S_WAIT: begin
          stb_cnt_n = lock_s ? stb_cnt + 1'b1 : '0;
          to_cnt_n  = to_cnt + 1'b1;
          if (lock_s && stb_cnt == STB_W'(LOCK_STABLE_CYCLES - 1)) begin
            state_n = S_RELEASE;
          end else if (to_cnt == TO_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
            if (retry_cnt == 8'(MAX_RETRIES)) begin
              state_n = S_FAULT;
            end else begin
              retry_n = retry_cnt + 1'b1;
              state_n = S_PLLRST;
            end
          end
        end
        S_RELEASE, S_RUN: begin
          if (!lock_s) begin
            state_n = S_PLLRST;
            if (loss_cnt != '1)
              loss_n = loss_cnt + 1'b1;
          end else if (state == S_RELEASE) begin
            if (rel_cnt == REL_W'(REL_LAST))
              state_n = S_RUN;
            else
              rel_cnt_n = rel_cnt + 1'b1;
          end
        end
        S_FAULT: begin
          state_n = S_FAULT;
        end
        default: begin
          state_n = S_PLLRST;
        end
      endcase
    end

    if (state_n != state) begin
      rst_cnt_n = '0;
      stb_cnt_n = '0;
      to_cnt_n  = '0;
      rel_cnt_n = '0;
    end

    if (state_n == S_RUN) begin
      retry_n = '0;
      ch_n    = '1;
    end else if (state == S_RELEASE && state_n == S_RELEASE) begin
      for (int k = 0; k < NUM_CH; k++)
        ch_n[k] = (rel_cnt >= REL_W'(k * STAGGER_CYCLES));
    end

    pll_reset_n = (state_n == S_PLLRST) || (state_n == S_FAULT);
    ready_n     = (state_n == S_RUN);
    fault_n     = (state_n == S_FAULT);
  end

  // State, counters and all outputs
  always_ff @(posedge clkin or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state     <= S_PLLRST;
      rst_cnt   <= '0;
      stb_cnt   <= '0;
      to_cnt    <= '0;
      rel_cnt   <= '0;
      pll_reset <= 1'b1;
      ch_rst_n  <= '0;
      ready     <= 1'b0;
      fault     <= 1'b0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
    end else begin
      state     <= state_n;
      rst_cnt   <= rst_cnt_n;
      stb_cnt   <= stb_cnt_n;
      to_cnt    <= to_cnt_n;
      rel_cnt   <= rel_cnt_n;
      pll_reset <= pll_reset_n;
      ch_rst_n  <= ch_n;
      ready     <= ready_n;
      fault     <= fault_n;
      retry_cnt <= retry_n;
      loss_cnt  <= loss_n;
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer.
// Small parameter set, hand-computed edge numbers.
module tb_pll_lock_sequencer;

  logic        clkin;
  logic        reset_n;
  logic        lock_in;
  logic        restart;
  logic        pll_reset;
  logic [2:0]  ch_rst_n;
  logic        ready;
  logic        fault;
  logic [7:0]  retry_cnt;
  logic [15:0] loss_cnt;

  int checks = 0;
  int fails  = 0;

  pll_lock_sequencer #(
    .PLL_RST_CYCLES      (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32),
    .NUM_CH              (3),
    .STAGGER_CYCLES      (2),
    .MAX_RETRIES         (2)
  ) dut (
    .clkin     (clkin),
    .reset_n   (reset_n),
    .lock_in   (lock_in),
    .restart   (restart),
    .pll_reset (pll_reset),
    .ch_rst_n  (ch_rst_n),
    .ready     (ready),
    .fault     (fault),
    .retry_cnt (retry_cnt),
    .loss_cnt  (loss_cnt)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  // Edge 1 is the first rising edge after reset_n is released.
  task automatic apply_reset();
    @(negedge clkin);
    reset_n = 1'b0;
    restart = 1'b0;
    repeat (3) @(negedge clkin);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if (pll_reset !== 1'b1) begin
      fails++; $display("FAIL reset_pll_reset got %b want 1", pll_reset);
    end
    checks++;
    if (ch_rst_n !== 3'b000) begin
      fails++; $display("FAIL reset_ch got %b want 000", ch_rst_n);
    end
    checks++;
    if (ready !== 1'b0 || fault !== 1'b0) begin
      fails++; $display("FAIL reset_flags got ready=%b fault=%b want 0 0", ready, fault);
    end
    checks++;
    if (retry_cnt !== 8'd0 || loss_cnt !== 16'd0) begin
      fails++; $display("FAIL reset_counts got retry=%0d loss=%0d want 0 0", retry_cnt, loss_cnt);
    end
  endtask

  // pll_reset falls at 2 (reset sync) + 4; release at +8; channels at +1,+3,+5; ready +6
  task automatic test_clean_bringup();
    int t_fall, t_c1, t_c3, t_c7, t_rdy;
    t_fall = -1; t_c1 = -1; t_c3 = -1; t_c7 = -1; t_rdy = -1;
    lock_in = 1'b1;
    apply_reset();
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (t_fall < 0 && pll_reset === 1'b0) t_fall = i;
      if (t_c1 < 0 && ch_rst_n === 3'b001) t_c1 = i;
      if (t_c3 < 0 && ch_rst_n === 3'b011) t_c3 = i;
      if (t_c7 < 0 && ch_rst_n === 3'b111) t_c7 = i;
      if (t_rdy < 0 && ready === 1'b1) t_rdy = i;
    end
    checks++;
    if (t_fall != 6) begin
      fails++; $display("FAIL clean_pll_fall got edge %0d want 6", t_fall);
    end
    checks++;
    if (t_c1 != 15) begin
      fails++; $display("FAIL clean_ch001 got edge %0d want 15", t_c1);
    end
    checks++;
    if (t_c3 != 17) begin
      fails++; $display("FAIL clean_ch011 got edge %0d want 17", t_c3);
    end
    checks++;
    if (t_c7 != 19) begin
      fails++; $display("FAIL clean_ch111 got edge %0d want 19", t_c7);
    end
    checks++;
    if (t_rdy != 20) begin
      fails++; $display("FAIL clean_ready got edge %0d want 20", t_rdy);
    end
    checks++;
    if (retry_cnt !== 8'd0 || pll_reset !== 1'b0) begin
      fails++; $display("FAIL clean_final got retry=%0d pll_reset=%b want 0 0", retry_cnt, pll_reset);
    end
  endtask

  // lock_in low for edge 11 only; FSM sees it at edge 13 and restarts the count
  task automatic test_glitchy_lock();
    int t_c1, t_rdy;
    t_c1 = -1; t_rdy = -1;
    lock_in = 1'b1;
    apply_reset();
    for (int i = 1; i <= 35; i++) begin
      lock_in = (i != 11);
      tick();
      if (t_c1 < 0 && ch_rst_n === 3'b001) t_c1 = i;
      if (t_rdy < 0 && ready === 1'b1) t_rdy = i;
    end
    checks++;
    if (t_c1 != 22) begin
      fails++; $display("FAIL glitch_ch001 got edge %0d want 22", t_c1);
    end
    checks++;
    if (t_rdy != 27) begin
      fails++; $display("FAIL glitch_ready got edge %0d want 27", t_rdy);
    end
  endtask

  task automatic test_timeout_fault();
    int t_fall, t_rise, t_r1, t_r2, t_flt;
    t_fall = -1; t_rise = -1; t_r1 = -1; t_r2 = -1; t_flt = -1;
    lock_in = 1'b0;
    apply_reset();
    for (int i = 1; i <= 115; i++) begin
      tick();
      if (t_fall < 0 && pll_reset === 1'b0) t_fall = i;
      if (t_fall > 0 && t_rise < 0 && pll_reset === 1'b1) t_rise = i;
      if (t_r1 < 0 && retry_cnt === 8'd1) t_r1 = i;
      if (t_r2 < 0 && retry_cnt === 8'd2) t_r2 = i;
      if (t_flt < 0 && fault === 1'b1) t_flt = i;
    end
    checks++;
    if (t_rise != 38) begin
      fails++; $display("FAIL timeout_pll_rise got edge %0d want 38", t_rise);
    end
    checks++;
    if (t_r1 != 38) begin
      fails++; $display("FAIL timeout_retry1 got edge %0d want 38", t_r1);
    end
    checks++;
    if (t_r2 != 74) begin
      fails++; $display("FAIL timeout_retry2 got edge %0d want 74", t_r2);
    end
    checks++;
    if (t_flt != 110) begin
      fails++; $display("FAIL timeout_fault got edge %0d want 110", t_flt);
    end
    checks++;
    if (pll_reset !== 1'b1 || ch_rst_n !== 3'b000 || retry_cnt !== 8'd2) begin
      fails++;
      $display("FAIL fault_outputs got pll=%b ch=%b retry=%0d want 1 000 2",
               pll_reset, ch_rst_n, retry_cnt);
    end
  endtask

  task automatic test_restart_from_fault();
    int t_fall, t_c1, t_rdy;
    t_fall = -1; t_c1 = -1; t_rdy = -1;
    lock_in = 1'b1;
    repeat (4) tick();
    checks++;
    if (fault !== 1'b1) begin
      fails++; $display("FAIL fault_sticky got %b want 1", fault);
    end
    restart = 1'b1;
    tick();
    restart = 1'b0;
    checks++;
    if (fault !== 1'b0 || retry_cnt !== 8'd0 || pll_reset !== 1'b1) begin
      fails++;
      $display("FAIL restart_clear got fault=%b retry=%0d pll=%b want 0 0 1",
               fault, retry_cnt, pll_reset);
    end
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (t_fall < 0 && pll_reset === 1'b0) t_fall = i;
      if (t_c1 < 0 && ch_rst_n === 3'b001) t_c1 = i;
      if (t_rdy < 0 && ready === 1'b1) t_rdy = i;
    end
    checks++;
    if (t_fall != 4) begin
      fails++; $display("FAIL restart_pll_fall got edge %0d want 4", t_fall);
    end
    checks++;
    if (t_c1 != 13) begin
      fails++; $display("FAIL restart_ch001 got edge %0d want 13", t_c1);
    end
    checks++;
    if (t_rdy != 18) begin
      fails++; $display("FAIL restart_ready got edge %0d want 18", t_rdy);
    end
  endtask

  task automatic test_lock_loss();
    int t_fall, t_rdy;
    t_fall = -1; t_rdy = -1;
    lock_in = 1'b0;
    tick();
    lock_in = 1'b1;
    tick();
    checks++;
    if (ch_rst_n !== 3'b111 || ready !== 1'b1) begin
      fails++; $display("FAIL loss_edge2 got ch=%b ready=%b want 111 1", ch_rst_n, ready);
    end
    tick();
    checks++;
    if (ch_rst_n !== 3'b000 || ready !== 1'b0 || pll_reset !== 1'b1) begin
      fails++;
      $display("FAIL loss_edge3 got ch=%b ready=%b pll=%b want 000 0 1",
               ch_rst_n, ready, pll_reset);
    end
    checks++;
    if (loss_cnt !== 16'd1) begin
      fails++; $display("FAIL loss_cnt got %0d want 1", loss_cnt);
    end
    for (int i = 4; i <= 30; i++) begin
      tick();
      if (t_fall < 0 && pll_reset === 1'b0) t_fall = i;
      if (t_rdy < 0 && ready === 1'b1) t_rdy = i;
    end
    checks++;
    if (t_fall != 7) begin
      fails++; $display("FAIL loss_pll_fall got edge %0d want 7", t_fall);
    end
    checks++;
    if (t_rdy != 21) begin
      fails++; $display("FAIL loss_ready got edge %0d want 21", t_rdy);
    end
    checks++;
    if (retry_cnt !== 8'd0 || loss_cnt !== 16'd1) begin
      fails++; $display("FAIL loss_final got retry=%0d loss=%0d want 0 1", retry_cnt, loss_cnt);
    end
  endtask

  task automatic test_async_reset_mid_release();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    for (int i = 1; i <= 15; i++) tick();
    checks++;
    if (ch_rst_n !== 3'b011 || loss_cnt !== 16'd1) begin
      fails++; $display("FAIL midrel_pre got ch=%b loss=%0d want 011 1", ch_rst_n, loss_cnt);
    end
    @(negedge clkin);
    reset_n = 1'b0;
    #1;
    checks++;
    if (ch_rst_n !== 3'b000 || pll_reset !== 1'b1) begin
      fails++; $display("FAIL async_rst got ch=%b pll=%b want 000 1", ch_rst_n, pll_reset);
    end
    checks++;
    if (loss_cnt !== 16'd0 || ready !== 1'b0) begin
      fails++; $display("FAIL async_rst_cnt got loss=%0d ready=%b want 0 0", loss_cnt, ready);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    lock_in = 1'b1;
    restart = 1'b0;
    test_reset();
    test_clean_bringup();
    test_glitchy_lock();
    test_timeout_fault();
    test_restart_from_fault();
    test_lock_loss();
    test_async_reset_mid_release();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
